// File: rtl/detector_release_ctrl_pkg.sv
// Shared types and defaults for the 10110 detector release controller.
package detector_release_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StCount   = 2'b01,
        StRelease = 2'b10
    } state_e;

    localparam int unsigned DefCntW  = 8;
    localparam int unsigned DefSessW = 16;

endpackage

// File: rtl/ld_down_counter.sv
// Loadable down counter that stops at zero, with zero/one flags.
module ld_down_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         zero,
    output logic         one
);

    logic [W-1:0] cnt_q, cnt_d;

    // Load wins over decrement; decrement is ignored at zero so the count never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);
    assign one  = (cnt_q == W'(1));

endmodule

// File: rtl/detector_release_ctrl.sv
// Holds the 10110 detector in its wait state for a programmable number of enabled
// cycles, then releases it; reports aborts, completed sessions and protocol errors.
module detector_release_ctrl
    import detector_release_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W  = DefCntW,
    parameter int unsigned SESS_W = DefSessW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i0,
    input  logic              w,
    input  logic              en,
    input  logic [CNT_W-1:0]  len,
    input  logic              clr_err,
    output logic              cntrl,
    output logic              busy,
    output logic [CNT_W-1:0]  remaining,
    output logic              abort,
    output logic [SESS_W-1:0] sessions,
    output logic              err
);

    state_e              state_q, state_d;
    logic                abort_q, abort_d;
    logic                err_q, err_d, err_set;
    logic [SESS_W-1:0]   sessions_q, sessions_d;
    logic                cnt_load, cnt_dec, cnt_zero, cnt_one;
    logic [CNT_W-1:0]    cnt_load_val;

    ld_down_counter #(
        .W (CNT_W)
    ) u_hold_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .cnt      (remaining),
        .zero     (cnt_zero),
        .one      (cnt_one)
    );

    always_comb begin
        state_d      = state_q;
        abort_d      = 1'b0;
        err_set      = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        case (state_q)
            StCount: begin
                // A second init pulse mid-session is a protocol error but never reloads.
                if (i0) begin
                    err_set = 1'b1;
                end
                if (!w) begin
                    abort_d  = 1'b1;
                    cnt_load = 1'b1;
                    state_d  = StIdle;
                end else if (en) begin
                    cnt_dec = 1'b1;
                    if (cnt_one || cnt_zero) begin
                        state_d = StRelease;
                    end
                end
            end
            StRelease: begin
                state_d = StIdle;
            end
            default: begin
                if (i0) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = (len == '0) ? CNT_W'(1) : len;
                    state_d      = StCount;
                end else if (w) begin
                    // Orphan wait: release anyway so the detector cannot deadlock.
                    err_set = 1'b1;
                    state_d = StRelease;
                end
            end
        endcase
    end

    always_comb begin
        sessions_d = sessions_q;
        if ((state_q == StRelease) && (sessions_q != '1)) begin
            sessions_d = sessions_q + SESS_W'(1);
        end
        err_d = err_set ? 1'b1 : (clr_err ? 1'b0 : err_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            abort_q    <= 1'b0;
            err_q      <= 1'b0;
            sessions_q <= '0;
        end else begin
            state_q    <= state_d;
            abort_q    <= abort_d;
            err_q      <= err_d;
            sessions_q <= sessions_d;
        end
    end

    assign cntrl    = (state_q == StRelease);
    assign busy     = (state_q == StCount) || (state_q == StRelease);
    assign abort    = abort_q;
    assign sessions = sessions_q;
    assign err      = err_q;

endmodule
